// File: rtl/spi_frame_ctrl_if.sv
// Bus bundle between the SPI slave / sample producer and spi_frame_ctrl.
interface spi_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_NUM    = 8
);
  logic [DATA_WIDTH-1:0] rxd_data;
  logic                  flag_done;
  logic                  fifo_wr_en;
  logic [7:0]            fifo_wr_data;
  logic [DATA_WIDTH-1:0] txd_data;
  logic [8*REG_NUM-1:0]  reg_q;
  logic                  fifo_full;
  logic                  fifo_empty;

  modport master (
    output rxd_data, flag_done, fifo_wr_en, fifo_wr_data,
    input  txd_data, reg_q, fifo_full, fifo_empty
  );

  modport slave (
    input  rxd_data, flag_done, fifo_wr_en, fifo_wr_data,
    output txd_data, reg_q, fifo_full, fifo_empty
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI frame decoder/responder: register file, ID read, sample-FIFO pops.
// Define SPI_FRAME_WR_ECHO_EN to make write frames respond with status and echoed data.
module spi_frame_ctrl #(
  parameter int         DATA_WIDTH = 16,
  parameter int         REG_NUM    = 8,
  parameter logic [7:0] DEV_ID     = 8'h5A,
  parameter logic [6:0] FIFO_ADDR  = 7'h7F,
  parameter int         FIFO_DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  spi_frame_ctrl_if.slave  bus
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RIW = $clog2(REG_NUM);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {A_ID, A_REG, A_FIFO, A_INV} acls_t;

  state_t                    state;
  acls_t                     acls;
  logic [DATA_WIDTH-1:0]     frame;
  logic                      rw;
  logic [6:0]                addr;
  logic [7:0]                wdata;
  logic [DATA_WIDTH-1:0]     txd;
  logic [REG_NUM-1:0][7:0]   regs;
  logic                      ovr, fovf;

  logic [7:0]                mem [FIFO_DEPTH];
  logic [PW-1:0]             wptr, rptr;
  logic [PW:0]               cnt, cnt_ap;
  logic                      full, empty, push, push_drop, pop;

  assign full      = (cnt == (PW+1)'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign push      = bus.fifo_wr_en && !full;
  assign push_drop = bus.fifo_wr_en && full;
  assign pop       = (state == S_EXEC) && rw && (acls == A_FIFO) && !empty;
  // Status flags reflect the FIFO after this frame's pop, ignoring a concurrent push.
  assign cnt_ap    = cnt - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= bus.fifo_wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  function automatic acls_t classify(input logic [6:0] a);
    if (a == 7'd0)                 return A_ID;
    else if (a == FIFO_ADDR)       return A_FIFO;
    else if (a < 7'(REG_NUM))      return A_REG;
    else                           return A_INV;
  endfunction

  logic                  err_x, has_status, rep;
  logic [7:0]            rdata_x;
  logic [7:0]            status_x;
  logic [DATA_WIDTH-1:0] txd_next;

  always_comb begin
    err_x      = 1'b0;
    rdata_x    = 8'h00;
    has_status = 1'b1;
    if (rw) begin
      case (acls)
        A_ID:    rdata_x = DEV_ID;
        A_REG:   rdata_x = regs[addr[RIW-1:0]];
        A_FIFO:  if (empty) err_x = 1'b1; else rdata_x = mem[rptr];
        default: err_x = 1'b1;
      endcase
    end else begin
      err_x = (acls != A_REG);
`ifdef SPI_FRAME_WR_ECHO_EN
      rdata_x = (acls == A_REG) ? wdata : 8'h00;
`else
      has_status = 1'b0;
`endif
    end
    status_x = {1'b1, err_x, (cnt_ap == '0), (cnt_ap == (PW+1)'(FIFO_DEPTH)), fovf, ovr, 2'b00};
    txd_next = has_status ? {status_x, rdata_x} : '0;
  end

  // A response that carries STATUS consumes the sticky bits it reported; new events still land.
  assign rep = (state == S_EXEC) && has_status;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acls  <= A_ID;
      frame <= '0;
      rw    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      txd   <= '0;
      regs  <= '0;
      ovr   <= 1'b0;
      fovf  <= 1'b0;
    end else begin
      ovr  <= (ovr && !rep) || (bus.flag_done && state != S_IDLE);
      fovf <= (fovf && !rep) || push_drop;
      case (state)
        S_IDLE: if (bus.flag_done) begin
          frame <= bus.rxd_data;
          txd   <= '0;
          state <= S_DECODE;
        end
        S_DECODE: begin
          rw    <= frame[DATA_WIDTH-1];
          addr  <= frame[14:8];
          wdata <= frame[7:0];
          acls  <= classify(frame[14:8]);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!rw && acls == A_REG) regs[addr[RIW-1:0]] <= wdata;
          txd   <= txd_next;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.txd_data   = txd;
  assign bus.reg_q      = regs;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: per-cycle model compare plus directed literal checks.
module tb_spi_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_frame_ctrl_if #(.DATA_WIDTH(16), .REG_NUM(8)) bus ();
  spi_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Model: frame accepted at an idle edge executes two edges later; busy for three edges.
  logic [7:0]  m_reg [8];
  logic [7:0]  q[$];
  bit          m_ovr, m_fovf, m_pend, m_rep, m_stat, m_err;
  int          m_age, pre_sz;
  logic [15:0] m_txd, m_frame;
  logic [7:0]  m_rd;
  logic [6:0]  m_a;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      q.delete();
      m_ovr = 0; m_fovf = 0; m_pend = 0; m_age = 0; m_txd = 16'h0000;
    end else begin
      pre_sz = q.size();
      m_rep  = 0;
      if (m_pend) begin
        m_age++;
        if (m_age == 2) begin
          m_a = m_frame[14:8]; m_rd = 8'h00; m_err = 0; m_stat = 1;
          if (m_frame[15]) begin
            if (m_a == 0) m_rd = 8'h5A;
            else if (m_a == 7'h7F) begin
              if (q.size() > 0) m_rd = q.pop_front(); else m_err = 1;
            end else if (m_a < 8) m_rd = m_reg[int'(m_a)];
            else m_err = 1;
          end else begin
            if (m_a >= 1 && m_a < 8) m_reg[int'(m_a)] = m_frame[7:0]; else m_err = 1;
`ifdef SPI_FRAME_WR_ECHO_EN
            m_rd = m_err ? 8'h00 : m_frame[7:0];
`else
            m_stat = 0;
`endif
          end
          m_txd = m_stat ? {1'b1, m_err, q.size() == 0, q.size() == 16, m_fovf, m_ovr, 2'b00, m_rd}
                         : 16'h0000;
          m_rep = m_stat;
        end
        if (m_age == 3) m_pend = 0;
        m_ovr = (m_ovr && !m_rep) || bus.flag_done;
      end else begin
        m_ovr = m_ovr && !m_rep;
        if (bus.flag_done) begin
          m_pend = 1; m_age = 0; m_frame = bus.rxd_data; m_txd = 16'h0000;
        end
      end
      m_fovf = (m_fovf && !m_rep) || (bus.fifo_wr_en && pre_sz == 16);
      if (bus.fifo_wr_en && pre_sz < 16) q.push_back(bus.fifo_wr_data);
    end
  end

  logic [63:0] m_regq;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) m_regq[8*i +: 8] = m_reg[i];
      chk("cyc_txd", 64'(bus.txd_data), 64'(m_txd));
      chk("cyc_reg_q", bus.reg_q, m_regq);
      chk("cyc_full", 64'(bus.fifo_full), 64'(q.size() == 16));
      chk("cyc_empty", 64'(bus.fifo_empty), 64'(q.size() == 0));
    end
  end

  task automatic send(input logic [15:0] f);
    @(negedge clk);
    bus.rxd_data = f; bus.flag_done = 1'b1;
    @(negedge clk);
    bus.flag_done = 1'b0;
  endtask

  // Send, then sample txd_data in the T+3 cycle and idle a few cycles.
  task automatic xfer(input string nm, input logic [15:0] f, input logic [15:0] exp);
    send(f);
    repeat (2) @(negedge clk);
    chk(nm, 64'(bus.txd_data), 64'(exp));
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.fifo_wr_en = 1'b1; bus.fifo_wr_data = b;
  endtask

  task automatic push_end();
    @(negedge clk);
    bus.fifo_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxd_data = '0; bus.flag_done = 1'b0; bus.fifo_wr_en = 1'b0; bus.fifo_wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_txd", 64'(bus.txd_data), 64'h0);
    chk("rst_reg_q", bus.reg_q, 64'h0);
    chk("rst_empty", 64'(bus.fifo_empty), 64'h1);
    chk("rst_full", 64'(bus.fifo_full), 64'h0);

    xfer("id_read", 16'h8000, 16'hA05A);

`ifndef SPI_FRAME_WR_ECHO_EN
    xfer("wr_reg3", 16'h03C3, 16'h0000);
`else
    xfer("wr_reg3", 16'h03C3, 16'hA0C3);
`endif
    chk("reg3_q", 64'(bus.reg_q[31:24]), 64'hC3);
    xfer("rd_reg3", 16'h8300, 16'hA0C3);

    push(8'h11); push(8'h22); push_end();
    xfer("fifo_pop1", 16'hFF00, 16'h8011);
    xfer("fifo_pop2", 16'hFF00, 16'hA022);
    xfer("fifo_pop_empty", 16'hFF00, 16'hE000);
    xfer("rd_invalid", 16'h8900, 16'hE000);

    for (int i = 0; i < 17; i++) push(8'h08 + 8'(i));
    push_end();
    chk("fifo_full_17", 64'(bus.fifo_full), 64'h1);
    xfer("fovf_report", 16'hFF00, 16'h8808);
    xfer("fovf_cleared", 16'hFF00, 16'h8009);

    // Second strobe one cycle after an accepted frame must be dropped.
    send(16'h8000);
    bus.rxd_data = 16'h0344; bus.flag_done = 1'b1;
    @(negedge clk);
    bus.flag_done = 1'b0;
    @(negedge clk);
    chk("ovr_report", 64'(bus.txd_data), 64'h845A);
    repeat (3) @(negedge clk);
    chk("dropped_no_wr", bus.reg_q, 64'h00000000C3000000);
`ifndef SPI_FRAME_WR_ECHO_EN
    xfer("wr_invalid", 16'h0955, 16'h0000);
`else
    xfer("wr_invalid", 16'h0955, 16'hC000);
`endif
    chk("wr_invalid_q", bus.reg_q, 64'h00000000C3000000);
    xfer("ovr_cleared", 16'h8000, 16'h805A);

    // Reset one cycle after a write strobe aborts the write.
    send(16'h0177);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_reg1", 64'(bus.reg_q[15:8]), 64'h0);
    chk("abort_txd", 64'(bus.txd_data), 64'h0);
    chk("abort_empty", 64'(bus.fifo_empty), 64'h1);
    xfer("idle_after_rst", 16'h8000, 16'hA05A);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
